lcd_bus_arbiter: RTL and testbench
==================================

# lcd_bus_arbiter

Shares the single write-only HD44780-style character-LCD bus between two requesters and sequences every bus transfer with correct setup, enable-pulse and hold timing. After reset it runs the LCD power-up delay and the fixed init command sequence on its own, then grants requesters round-robin. It sits between the text and message generators and the LCD pins, so no client drives `lcd_e` directly.

## Interface
Parameters:
- T_POWERUP, 750000: idle cycles after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 25: cycles with data and RS valid and E low before E rises.
- T_PULSE, 25: cycles E is high.
- T_HOLD, 2000: cycles after E falls for a normal command or data write.
- T_CLEAR, 82000: hold cycles for a long command (RS=0 and data in 0x01..0x03).
- CNT_W, 22: timer width. It must hold the largest T_* value.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- c0_req  in  1  client 0 requests a write. Hold it high with c0_rs and c0_data stable until c0_ack.
- c0_rs  in  1  client 0 register select (0 = command, 1 = data).
- c0_data  in  8  client 0 byte.
- c0_ack  out  1  one-cycle pulse when client 0's byte is captured.
- c1_req, c1_rs, c1_data, c1_ack: same as client 0, for client 1.
- ready  out  1  high once the init sequence has completed.
- busy  out  1  high whenever the FSM is outside IDLE.
- lcd_data  out  8  LCD DB7..DB0.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  LCD RW. Constant 0 (write only).
- lcd_e  out  1  LCD enable.

## Operation
- States: POWERUP, INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE, SETUP, PULSE, HOLD.
- POWERUP: count T_POWERUP cycles, then go to INIT_SETUP with init index 0.
- INIT sequence: drive rs=0 and the bytes 0x38, 0x06, 0x0C, 0x01 in that order. Each byte goes through the setup, pulse and hold phases. 0x01 uses T_CLEAR. After the 4th hold completes, set ready=1 and enter IDLE.
- IDLE arbitration happens only when ready=1:
  - Exactly one req high: grant that client.
  - Both req high: grant the client named by the priority pointer.
  - After each grant, the pointer moves to the other client.
  - The pointer resets to client 0.
- On a grant:
  - Capture {rs, data} into the output register.
  - Pulse the granted ack for one cycle, in the first cycle of SETUP.
  - Go to SETUP.
- SETUP, then PULSE, then HOLD, then IDLE. The hold length is T_CLEAR when rs=0 and data[7:2]=0 and data≠0; otherwise it is T_HOLD.
- Requests are never acked while ready=0.
- A request dropped before its ack produces no transfer.
- A client that keeps req high after its ack is treated as a new request.
- lcd_data and lcd_rs change only on entry to SETUP or INIT_SETUP. They stay stable through the end of the hold.
- Reset mid-operation:
  - lcd_e drops immediately (asynchronous).
  - All state clears and the full power-up and init sequence re-runs.
  - No ack is issued for a transfer that was in flight.

## Timing
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, c0_ack=0, c1_ack=0, ready=0, busy=1 (state POWERUP), priority pointer=0.
- All outputs are registered.
- Grant latency: ack is asserted the cycle after IDLE samples req.
- Per-transfer bus timing, counted from the ack cycle:
  - E is low for T_SETUP cycles.
  - E is high for exactly T_PULSE cycles.
  - E is low for T_HOLD (or T_CLEAR) cycles.
  - The FSM then spends one IDLE cycle before the next grant.
- Minimum ack-to-ack spacing is T_SETUP+T_PULSE+T_HOLD+1 cycles.
- Each timer counts 0..T-1 and asserts done at T-1. The counter does not wrap.

## Structure
- Package lcd_pkg:
  - state enum;
  - init command array {0x38, 0x06, 0x0C, 0x01} and its length, 4;
  - default timing constants;
  - function is_long_cmd(rs, data).
- Sub-module lcd_timer, one instance:
  - inputs: load, with a load value of CNT_W bits;
  - output: done, high on the final cycle;
  - shared by every phase.
- The FSM, round-robin pointer and output register stay in lcd_bus_arbiter.

## Test plan
All scenarios use T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_HOLD=5, T_CLEAR=20.
- Release rst_n → 10 cycles idle, then 4 transfers 0x38, 0x06, 0x0C, 0x01 with lcd_rs=0, each with E high for 3 cycles. The last hold is 20 cycles, then ready=1.
- After ready, c0 writes rs=1, data 0x48 → c0_ack high for 1 cycle, lcd_data=0x48 and lcd_rs=1 stable for 10 cycles, E high for cycles 2..4 after the ack.
- c0_req and c1_req held high together → acks alternate c0, c1, c0, c1, spaced 11 cycles apart.
- c1 writes rs=0, 0x01 → hold of 20 cycles. c1 then writes rs=1, 0x01 → hold of 5 cycles.
- rst_n asserted during PULSE → lcd_e=0 immediately, no ack, ready=0, init sequence re-runs after release.
- c0_req raised during INIT → no c0_ack until ready=1. The first grant follows the init sequence.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state encoding, init command table, default timing and the
// long-command classifier for the character-LCD bus arbiter.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT_SETUP,
      ST_INIT_PULSE,
      ST_INIT_HOLD,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } lcd_state_e;

   localparam int unsigned INIT_LEN = 4;
   localparam int unsigned IDX_W    = $clog2(INIT_LEN);
   localparam logic [7:0]  INIT_CMDS [INIT_LEN] = '{8'h38, 8'h06, 8'h0C, 8'h01};

   localparam int unsigned T_POWERUP_DEF = 750000;
   localparam int unsigned T_SETUP_DEF   = 25;
   localparam int unsigned T_PULSE_DEF   = 25;
   localparam int unsigned T_HOLD_DEF    = 2000;
   localparam int unsigned T_CLEAR_DEF   = 82000;
   localparam int unsigned CNT_W_DEF     = 22;

   // Clear / return-home style commands need the long execution time.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Phase timer shared by every bus phase: load restarts it, done is high
// on the final cycle of the loaded length and the count then saturates.
module lcd_timer
   import lcd_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned RESET_LEN = T_POWERUP_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] lim_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         lim_q <= CNT_W'(RESET_LEN - 1);
      end else if (load_i) begin
         cnt_q <= '0;
         lim_q <= load_val_i - CNT_W'(1);
      end else if (!done_o) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign done_o = (cnt_q == lim_q);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-client round-robin arbiter for a write-only HD44780 bus; runs the
// power-up delay and init sequence itself before granting clients.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned T_POWERUP = T_POWERUP_DEF,
   parameter int unsigned T_SETUP   = T_SETUP_DEF,
   parameter int unsigned T_PULSE   = T_PULSE_DEF,
   parameter int unsigned T_HOLD    = T_HOLD_DEF,
   parameter int unsigned T_CLEAR   = T_CLEAR_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       c0_req,
   input  logic       c0_rs,
   input  logic [7:0] c0_data,
   output logic       c0_ack,
   input  logic       c1_req,
   input  logic       c1_rs,
   input  logic [7:0] c1_data,
   output logic       c1_ack,
   output logic       ready,
   output logic       busy,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e
);

   lcd_state_e       state_q;
   logic [IDX_W-1:0] init_idx_q;
   logic             ptr_q;
   logic             ready_q;
   logic             busy_q;
   logic             lcd_e_q;
   logic             lcd_rs_q;
   logic [7:0]       lcd_data_q;
   logic             c0_ack_q;
   logic             c1_ack_q;

   logic             grant;
   logic             grant_sel;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;

   // Single requester wins outright; a tie goes to the pointer.
   always_comb begin
      grant     = (state_q == ST_IDLE) && ready_q && (c0_req || c1_req);
      grant_sel = c1_req && (!c0_req || ptr_q);
   end

   // The timer is reloaded with the length of the phase being entered.
   always_comb begin
      tmr_load = (state_q == ST_IDLE) ? grant : tmr_done;
      tmr_val  = CNT_W'(T_SETUP);
      unique case (state_q)
         ST_INIT_SETUP, ST_SETUP: tmr_val = CNT_W'(T_PULSE);
         ST_INIT_PULSE, ST_PULSE:
            tmr_val = is_long_cmd(lcd_rs_q, lcd_data_q) ? CNT_W'(T_CLEAR) : CNT_W'(T_HOLD);
         default:                 tmr_val = CNT_W'(T_SETUP);
      endcase
   end

   lcd_timer #(
      .CNT_W     (CNT_W),
      .RESET_LEN (T_POWERUP)
   ) u_timer (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_POWERUP;
         init_idx_q <= '0;
         ptr_q      <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
         lcd_e_q    <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_data_q <= '0;
         c0_ack_q   <= 1'b0;
         c1_ack_q   <= 1'b0;
      end else begin
         c0_ack_q <= 1'b0;
         c1_ack_q <= 1'b0;
         unique case (state_q)
            ST_POWERUP: begin
               if (tmr_done) begin
                  state_q    <= ST_INIT_SETUP;
                  init_idx_q <= '0;
                  lcd_rs_q   <= 1'b0;
                  lcd_data_q <= INIT_CMDS[0];
               end
            end
            ST_INIT_SETUP: begin
               if (tmr_done) begin
                  state_q <= ST_INIT_PULSE;
                  lcd_e_q <= 1'b1;
               end
            end
            ST_INIT_PULSE: begin
               if (tmr_done) begin
                  state_q <= ST_INIT_HOLD;
                  lcd_e_q <= 1'b0;
               end
            end
            ST_INIT_HOLD: begin
               if (tmr_done) begin
                  if (init_idx_q == IDX_W'(INIT_LEN - 1)) begin
                     state_q <= ST_IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= ST_INIT_SETUP;
                     init_idx_q <= init_idx_q + IDX_W'(1);
                     lcd_data_q <= INIT_CMDS[init_idx_q + IDX_W'(1)];
                  end
               end
            end
            ST_IDLE: begin
               if (grant) begin
                  state_q    <= ST_SETUP;
                  busy_q     <= 1'b1;
                  ptr_q      <= ~grant_sel;
                  lcd_rs_q   <= grant_sel ? c1_rs : c0_rs;
                  lcd_data_q <= grant_sel ? c1_data : c0_data;
                  c0_ack_q   <= ~grant_sel;
                  c1_ack_q   <= grant_sel;
               end
            end
            ST_SETUP: begin
               if (tmr_done) begin
                  state_q <= ST_PULSE;
                  lcd_e_q <= 1'b1;
               end
            end
            ST_PULSE: begin
               if (tmr_done) begin
                  state_q <= ST_HOLD;
                  lcd_e_q <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (tmr_done) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_POWERUP;
         endcase
      end
   end

   assign c0_ack   = c0_ack_q;
   assign c1_ack   = c1_ack_q;
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign lcd_data = lcd_data_q;
   assign lcd_rs   = lcd_rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_e    = lcd_e_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: expected acks and bus transfers are
// queued as stimulus is driven and compared by a pin-level monitor.
module tb_lcd_bus_arbiter;

   localparam int TPU = 10;
   localparam int TS  = 2;
   localparam int TP  = 3;
   localparam int TH  = 5;
   localparam int TC  = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       c0_req, c0_rs, c1_req, c1_rs;
   logic [7:0] c0_data, c1_data;
   logic       c0_ack, c1_ack, ready, busy, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         setup;
      int         pulse;
      int         post;
   } xfer_t;

   xfer_t xq[$];
   int    aq[$];

   lcd_bus_arbiter #(
      .T_POWERUP (TPU),
      .T_SETUP   (TS),
      .T_PULSE   (TP),
      .T_HOLD    (TH),
      .T_CLEAR   (TC),
      .CNT_W     (22)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .c0_req   (c0_req),
      .c0_rs    (c0_rs),
      .c0_data  (c0_data),
      .c0_ack   (c0_ack),
      .c1_req   (c1_req),
      .c1_rs    (c1_rs),
      .c1_data  (c1_data),
      .c1_ack   (c1_ack),
      .ready    (ready),
      .busy     (busy),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_xfer(input logic rs, input logic [7:0] d, input int setup, input int post);
      xfer_t x;
      x.rs = rs; x.data = d; x.setup = setup; x.pulse = TP; x.post = post;
      xq.push_back(x);
   endtask

   task automatic push_init();
      push_xfer(1'b0, 8'h38, 0, TH);
      push_xfer(1'b0, 8'h06, 0, TH);
      push_xfer(1'b0, 8'h0C, 0, TH);
      push_xfer(1'b0, 8'h01, 0, TC);
   endtask

   // Pin-level monitor: reconstructs each E pulse and the hold that follows.
   logic  m_in_pulse, m_in_post, m_ack_seen, m_unstable, m_prev_ack;
   int    m_pw, m_post, m_setup;
   xfer_t m_cur;

   task automatic finish_xfer();
      xfer_t e;
      check("xfer_expected", xq.size() > 0, 1'b1);
      if (xq.size() > 0) begin
         e = xq.pop_front();
         check("xfer_rs",     m_cur.rs,    e.rs);
         check("xfer_data",   m_cur.data,  e.data);
         check("xfer_setup",  m_cur.setup, e.setup);
         check("xfer_pulse",  m_cur.pulse, e.pulse);
         check("xfer_hold",   m_post,      e.post);
         check("xfer_stable", m_unstable,  1'b0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         m_in_pulse = 1'b0; m_in_post = 1'b0; m_ack_seen = 1'b0;
         m_unstable = 1'b0; m_prev_ack = 1'b0;
      end else begin
         if (m_in_post) begin
            if (lcd_e || !busy || lcd_data !== m_cur.data || lcd_rs !== m_cur.rs) begin
               finish_xfer();
               m_in_post = 1'b0;
            end else begin
               m_post++;
            end
         end
         if (c0_ack || c1_ack) begin
            check("ack_single_cycle", m_prev_ack, 1'b0);
            check("ack_when_ready", ready, 1'b1);
            check("ack_exclusive", c0_ack & c1_ack, 1'b0);
            check("ack_expected", aq.size() > 0, 1'b1);
            if (aq.size() > 0) check("ack_client", c1_ack, aq.pop_front());
            m_ack_seen = 1'b1;
            m_setup    = 0;
         end
         m_prev_ack = c0_ack | c1_ack;
         if (lcd_e) begin
            if (!m_in_pulse) begin
               m_in_pulse = 1'b1;
               m_pw       = 0;
               m_unstable = 1'b0;
               m_cur.rs   = lcd_rs;
               m_cur.data = lcd_data;
               m_cur.setup = m_ack_seen ? m_setup : 0;
               m_ack_seen = 1'b0;
            end
            m_pw++;
            if (lcd_data !== m_cur.data || lcd_rs !== m_cur.rs) m_unstable = 1'b1;
         end else if (m_in_pulse) begin
            m_in_pulse  = 1'b0;
            m_cur.pulse = m_pw;
            m_in_post   = 1'b1;
            m_post      = 1;
         end else if (m_ack_seen) begin
            m_setup++;
         end
      end
   end

   task automatic wait_ack(output int t);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(c0_ack || c1_ack) && n < 400);
      check("ack_timeout", c0_ack | c1_ack, 1'b1);
      t = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while (busy && n < 400);
      check("idle_timeout", busy, 1'b0);
   endtask

   task automatic wait_ready(output int t);
      int n = 0;
      do begin @(negedge clk); n++; end while (!ready && n < 400);
      check("ready_timeout", ready, 1'b1);
      t = cyc;
   endtask

   task automatic wait_e();
      int n = 0;
      do begin @(negedge clk); n++; end while (!lcd_e && n < 400);
      check("e_timeout", lcd_e, 1'b1);
   endtask

   task automatic do_write(input int client, input logic rs, input logic [7:0] d, input int post);
      int t;
      aq.push_back(client);
      push_xfer(rs, d, TS, post);
      if (client == 0) begin c0_rs = rs; c0_data = d; c0_req = 1'b1; end
      else             begin c1_rs = rs; c1_data = d; c1_req = 1'b1; end
      wait_ack(t);
      c0_req = 1'b0;
      c1_req = 1'b0;
      wait_idle();
   endtask

   initial begin
      int t0, t_rdy, t_ack, ta[4];
      rst_n = 1'b0;
      c0_req = 1'b0; c0_rs = 1'b0; c0_data = '0;
      c1_req = 1'b0; c1_rs = 1'b0; c1_data = '0;
      repeat (2) @(negedge clk);
      check("rst_lcd_e",    lcd_e,    1'b0);
      check("rst_lcd_rs",   lcd_rs,   1'b0);
      check("rst_lcd_rw",   lcd_rw,   1'b0);
      check("rst_lcd_data", lcd_data, 8'h00);
      check("rst_c0_ack",   c0_ack,   1'b0);
      check("rst_c1_ack",   c1_ack,   1'b0);
      check("rst_ready",    ready,    1'b0);
      check("rst_busy",     busy,     1'b1);

      // Power-up, init sequence, and a request raised while init runs.
      push_init();
      aq.push_back(0);
      push_xfer(1'b1, 8'h48, TS, TH);
      rst_n = 1'b1;
      t0 = cyc;
      wait_e();
      check("powerup_to_first_e", cyc - t0, TPU + TS);
      c0_rs = 1'b1; c0_data = 8'h48; c0_req = 1'b1;
      check("ready_low_in_init", ready, 1'b0);
      wait_ready(t_rdy);
      wait_ack(t_ack);
      c0_req = 1'b0;
      check("first_grant_latency", t_ack - t_rdy, 1);
      wait_idle();

      // Single requests regardless of pointer, and long/short hold selection.
      do_write(0, 1'b0, 8'h04, TH);
      do_write(1, 1'b0, 8'h01, TC);
      do_write(1, 1'b1, 8'h01, TH);

      // A request withdrawn before IDLE samples it must not be acked.
      aq.push_back(1);
      push_xfer(1'b0, 8'h03, TS, TC);
      c1_rs = 1'b0; c1_data = 8'h03; c1_req = 1'b1;
      wait_ack(t_ack);
      c1_req = 1'b0;
      c0_rs = 1'b1; c0_data = 8'h77; c0_req = 1'b1;
      repeat (3) @(negedge clk);
      c0_req = 1'b0;
      wait_idle();

      // Both clients held: grants alternate starting from client 0.
      for (int i = 0; i < 4; i++) begin
         aq.push_back(i % 2);
         if (i % 2 == 0) push_xfer(1'b1, 8'h41, TS, TH);
         else            push_xfer(1'b1, 8'h62, TS, TH);
      end
      c0_rs = 1'b1; c0_data = 8'h41; c1_rs = 1'b1; c1_data = 8'h62;
      c0_req = 1'b1; c1_req = 1'b1;
      for (int i = 0; i < 4; i++) wait_ack(ta[i]);
      c0_req = 1'b0; c1_req = 1'b0;
      for (int i = 1; i < 4; i++) check("rr_ack_spacing", ta[i] - ta[i-1], TS + TP + TH + 1);
      wait_idle();

      // Reset while E is high aborts the transfer and re-runs init.
      aq.push_back(0);
      c0_rs = 1'b1; c0_data = 8'h55; c0_req = 1'b1;
      wait_ack(t_ack);
      c0_req = 1'b0;
      wait_e();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_lcd_e",  lcd_e,    1'b0);
      check("async_rst_ready",  ready,    1'b0);
      check("async_rst_busy",   busy,     1'b1);
      check("async_rst_c0_ack", c0_ack,   1'b0);
      check("async_rst_data",   lcd_data, 8'h00);
      repeat (3) @(negedge clk);
      push_init();
      aq.push_back(0);
      push_xfer(1'b1, 8'h30, TS, TH);
      aq.push_back(1);
      push_xfer(1'b1, 8'h31, TS, TH);
      rst_n = 1'b1;
      c0_rs = 1'b1; c0_data = 8'h30; c1_rs = 1'b1; c1_data = 8'h31;
      c0_req = 1'b1; c1_req = 1'b1;
      wait_ready(t_rdy);
      wait_ack(t_ack);
      c0_req = 1'b0;
      check("reinit_grant_latency", t_ack - t_rdy, 1);
      wait_ack(ta[0]);
      c1_req = 1'b0;
      check("reinit_ack_spacing", ta[0] - t_ack, TS + TP + TH + 1);
      wait_idle();
      repeat (3) @(negedge clk);

      check("end_xfer_queue_empty", xq.size(), 0);
      check("end_ack_queue_empty",  aq.size(), 0);
      check("end_lcd_rw",           lcd_rw,    1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
